// File: rtl/udp_arb_pkg.sv
// Shared types and widths for the UDP transmit arbiter.
package udp_arb_pkg;

  localparam int DATA_W = 8;
  localparam int USER_W = 12;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/udp_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester above the last winner, with wrap.
import udp_arb_pkg::*;

module rr_pick #(
  parameter int N_REQ = 2,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] last,
  output logic [N_REQ-1:0] winner,
  output logic [PTR_W-1:0] idx
);

  always_comb begin
    logic             found;
    logic [PTR_W-1:0] cand;
    winner = '0;
    idx    = '0;
    found  = 1'b0;
    cand   = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = PTR_W'((32'(last) + k) % N_REQ);
      if (!found && req[cand]) begin
        found        = 1'b1;
        winner[cand] = 1'b1;
        idx          = cand;
      end
    end
  end

endmodule

// File: rtl/udp_tx_arbiter.sv
// Packet-granular round-robin arbiter for the UDP TX stream with a post-frame idle gap.
// Optional per-requester frame counters on pkt_count when ARB_PKT_COUNT_EN is defined.
import udp_arb_pkg::*;

module udp_tx_arbiter #(
  parameter int N_REQ      = 2,
  parameter int GAP_CYCLES = 12
) (
  input  logic                      axis_aclk,
  input  logic                      axis_aresetn,
  input  logic [N_REQ-1:0]          s_axis_tvalid,
  output logic [N_REQ-1:0]          s_axis_tready,
  input  logic [N_REQ*DATA_W-1:0]   s_axis_tdata,
  input  logic [N_REQ-1:0]          s_axis_tlast,
  input  logic [N_REQ*USER_W-1:0]   s_axis_tuser,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [DATA_W-1:0]         m_axis_tdata,
  output logic                      m_axis_tlast,
  output logic [USER_W-1:0]         m_axis_tuser,
  output logic [N_REQ-1:0]          grant,
  output logic                      busy
`ifdef ARB_PKT_COUNT_EN
  ,
  output logic [N_REQ*CNT_W-1:0]    pkt_count
`endif
);

  localparam int PTR_W  = $clog2(N_REQ);
  localparam int GCNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  if (N_REQ < 2 || N_REQ > 4) begin : g_bad_n_req
    $error("udp_tx_arbiter: N_REQ must be in 2..4");
  end

  arb_state_t        state, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d, pick_win;
  logic [PTR_W-1:0]  last_q, last_d, pick_idx;
  logic [GCNT_W-1:0] gcnt_q, gcnt_d;
  logic              fire;

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req    (s_axis_tvalid),
    .last   (last_q),
    .winner (pick_win),
    .idx    (pick_idx)
  );

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state   <= IDLE;
      grant_q <= '0;
      last_q  <= PTR_W'(N_REQ - 1);
      gcnt_q  <= '0;
    end else begin
      state   <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      gcnt_q  <= gcnt_d;
    end
  end

  // last_q doubles as the owner index while BUSY, since it is loaded with the winner.
  always_comb begin
    state_d       = state;
    grant_d       = grant_q;
    last_d        = last_q;
    gcnt_d        = gcnt_q;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = '0;
    s_axis_tready = '0;
    fire          = 1'b0;
    unique case (state)
      IDLE: begin
        if (|s_axis_tvalid) begin
          state_d = BUSY;
          grant_d = pick_win;
          last_d  = pick_idx;
        end
      end
      BUSY: begin
        m_axis_tvalid = s_axis_tvalid[last_q];
        m_axis_tdata  = s_axis_tdata[last_q*DATA_W +: DATA_W];
        m_axis_tlast  = s_axis_tlast[last_q];
        m_axis_tuser  = s_axis_tuser[last_q*USER_W +: USER_W];
        s_axis_tready = grant_q & {N_REQ{m_axis_tready}};
        fire          = m_axis_tvalid & m_axis_tready & m_axis_tlast;
        if (fire) begin
          grant_d = '0;
          if (GAP_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d = GAP;
            gcnt_d  = GCNT_W'(GAP_CYCLES - 1);
          end
        end
      end
      GAP: begin
        if (gcnt_q == '0) state_d = IDLE;
        else              gcnt_d  = gcnt_q - GCNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant = grant_q;
  assign busy  = (state == BUSY);

`ifdef ARB_PKT_COUNT_EN
  logic [N_REQ*CNT_W-1:0] cnt_q;

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      cnt_q <= '0;
    end else if (fire) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (grant_q[i]) cnt_q[i*CNT_W +: CNT_W] <= cnt_q[i*CNT_W +: CNT_W] + CNT_W'(1);
      end
    end
  end

  assign pkt_count = cnt_q;
`endif

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Directed self-checking bench for udp_tx_arbiter (N_REQ=2, GAP_CYCLES=12).
module tb_udp_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  s_tvalid, s_tready, s_tlast;
  logic [15:0] s_tdata;
  logic [23:0] s_tuser;
  logic        m_tvalid, m_tready, m_tlast;
  logic [7:0]  m_tdata;
  logic [11:0] m_tuser;
  logic [1:0]  grant;
  logic        busy;
`ifdef ARB_PKT_COUNT_EN
  logic [31:0] pkt_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  udp_tx_arbiter #(
    .N_REQ      (2),
    .GAP_CYCLES (12)
  ) dut (
    .axis_aclk     (clk),
    .axis_aresetn  (rst_n),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tdata  (s_tdata),
    .s_axis_tlast  (s_tlast),
    .s_axis_tuser  (s_tuser),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tlast  (m_tlast),
    .m_axis_tuser  (m_tuser),
    .grant         (grant),
    .busy          (busy)
`ifdef ARB_PKT_COUNT_EN
    ,
    .pkt_count     (pkt_count)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Traffic configuration and observation logs for the run task.
  int len[2], frames_left[2], start_cyc[2], drop_beat[2], drop_left[2], beat[2], fnum[2];
  bit [7:0]   rdy_pat;
  int         rdy_len;
  logic [1:0] gseq[$];
  logic [7:0] odata[$];
  logic       olast[$];
  int         gaps[$];
  int         rdy_bad, user_bad, idle_bad;

  task automatic do_reset();
    rst_n    = 1'b0;
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    s_tuser  = '0;
    m_tready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic setup(input int l0, input int f0, input int l1, input int f1);
    len[0] = l0; frames_left[0] = f0;
    len[1] = l1; frames_left[1] = f1;
    for (int r = 0; r < 2; r++) begin
      start_cyc[r] = 0; drop_beat[r] = -1; drop_left[r] = 0; beat[r] = 0; fnum[r] = 0;
    end
    rdy_pat = 8'hFF; rdy_len = 1;
    gseq.delete(); odata.delete(); olast.delete(); gaps.delete();
    rdy_bad = 0; user_bad = 0; idle_bad = 0;
  endtask

  task automatic run(input string tag, input int max_cyc);
    logic [1:0] pg, exp_rdy;
    int         last_hs, owner;
    bit         dropping;
    pg = '0; last_hs = -1;
    for (int cyc = 0; cyc < max_cyc && (frames_left[0] + frames_left[1]) > 0; cyc++) begin
      @(negedge clk);
      for (int r = 0; r < 2; r++) begin
        dropping    = (beat[r] == drop_beat[r]) && (drop_left[r] > 0);
        s_tvalid[r] = (frames_left[r] > 0) && (cyc >= start_cyc[r]) && !dropping;
        if (dropping) drop_left[r]--;
        s_tdata[r*8 +: 8]   = {2'(r), 2'(fnum[r]), 4'(beat[r])};
        s_tlast[r]          = (beat[r] == len[r] - 1);
        s_tuser[r*12 +: 12] = 12'(len[r]);
      end
      m_tready = rdy_pat[cyc % rdy_len];
      #1;
      if (grant != 2'b00 && grant != pg) begin
        gseq.push_back(grant);
        if (last_hs >= 0) gaps.push_back(cyc - last_hs);
      end
      pg      = grant;
      exp_rdy = grant[0] ? {1'b0, m_tready} : (grant[1] ? {m_tready, 1'b0} : 2'b00);
      if (s_tready !== exp_rdy) rdy_bad++;
      if (m_tvalid && !busy) idle_bad++;
      owner = grant[1] ? 1 : 0;
      if (m_tvalid && m_tuser !== 12'(len[owner])) user_bad++;
      if (m_tvalid && m_tready) begin
        odata.push_back(m_tdata);
        olast.push_back(m_tlast);
        if (m_tlast) last_hs = cyc;
      end
      for (int r = 0; r < 2; r++) begin
        if (s_tvalid[r] && s_tready[r]) begin
          if (s_tlast[r]) begin beat[r] = 0; fnum[r]++; frames_left[r]--; end
          else beat[r]++;
        end
      end
    end
    check_eq({tag, "_timeout"}, 32'(frames_left[0] + frames_left[1]), 32'd0);
    check_eq({tag, "_tready"}, 32'(rdy_bad), 32'd0);
    check_eq({tag, "_tuser"}, 32'(user_bad), 32'd0);
    check_eq({tag, "_idle_xfer"}, 32'(idle_bad), 32'd0);
  endtask

  task automatic check_stream(input string tag, input logic [8:0] exp[$]);
    check_eq({tag, "_nbeats"}, 32'(odata.size()), 32'(exp.size()));
    foreach (exp[i])
      check_eq($sformatf("%s_beat%0d", tag, i),
               (i < odata.size()) ? 32'({olast[i], odata[i]}) : 32'hFFFF_FFFF, 32'(exp[i]));
  endtask

  task automatic check_grants(input string tag, input logic [1:0] exp[$]);
    check_eq({tag, "_ngrants"}, 32'(gseq.size()), 32'(exp.size()));
    foreach (exp[i])
      check_eq($sformatf("%s_grant%0d", tag, i),
               (i < gseq.size()) ? 32'(gseq[i]) : 32'hFFFF_FFFF, 32'(exp[i]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] es[$];
    logic [1:0] eg[$];
    int bad;

    // Test 1: reset state, 1-cycle arbitration, 3-beat frame, 12-cycle gap, single-beat frame.
    rst_n = 1'b0; s_tvalid = 2'b11; s_tlast = '0; s_tdata = '0; s_tuser = '0; m_tready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_grant", 32'(grant), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_mvalid", 32'(m_tvalid), 32'd0);
    check_eq("rst_sready", 32'(s_tready), 32'd0);
    check_eq("rst_mdata", 32'(m_tdata), 32'd0);
    s_tvalid = '0; m_tready = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    s_tvalid = 2'b01; s_tdata = 16'h00A1; s_tuser = 24'd3; s_tlast = 2'b00; m_tready = 1'b1;
    #1;
    check_eq("t1_idle_grant", 32'(grant), 32'd0);
    check_eq("t1_idle_mvalid", 32'(m_tvalid), 32'd0);
    check_eq("t1_idle_sready", 32'(s_tready), 32'd0);
    @(negedge clk); #1;
    check_eq("t1_grant", 32'(grant), 32'h1);
    check_eq("t1_busy", 32'(busy), 32'd1);
    check_eq("t1_a1", 32'(m_tdata), 32'hA1);
    check_eq("t1_a1_last", 32'(m_tlast), 32'd0);
    check_eq("t1_user", 32'(m_tuser), 32'd3);
    check_eq("t1_sready", 32'(s_tready), 32'h1);
    @(negedge clk); s_tdata = 16'h00A2; #1;
    check_eq("t1_a2", 32'(m_tdata), 32'hA2);
    @(negedge clk); s_tdata = 16'h00A3; s_tlast = 2'b01; #1;
    check_eq("t1_a3", 32'(m_tdata), 32'hA3);
    check_eq("t1_a3_last", 32'(m_tlast), 32'd1);
    bad = 0;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      if (i == 0) begin s_tdata = 16'h00B1; s_tuser = 24'd1; end
      #1;
      if (grant != 2'b00 || s_tready != 2'b00 || m_tvalid || busy) bad++;
    end
    check_eq("t1_gap_quiet", 32'(bad), 32'd0);
    @(negedge clk); #1;
    check_eq("t1_regrant", 32'(grant), 32'h1);
    check_eq("t1_b1", 32'(m_tdata), 32'hB1);
    check_eq("t1_b1_last", 32'(m_tlast), 32'd1);
    @(negedge clk); s_tvalid = '0;

    // Test 2: both requesters always valid, 2-beat frames -> strict alternation.
    do_reset();
    setup(2, 2, 2, 2);
    run("t2", 300);
    es = {9'h000, 9'h101, 9'h040, 9'h141, 9'h010, 9'h111, 9'h050, 9'h151};
    check_stream("t2", es);
    eg = {2'b01, 2'b10, 2'b01, 2'b10};
    check_grants("t2", eg);
    bad = 0;
    foreach (gaps[i]) if (gaps[i] != 14) bad++;
    check_eq("t2_ngaps", 32'(gaps.size()), 32'd3);
    check_eq("t2_gap_len", 32'(bad), 32'd0);

    // Test 3: 5-beat frame from req1 under backpressure pattern 1,0,0,1.
    do_reset();
    setup(1, 0, 5, 1);
    rdy_pat = 8'b0000_1001; rdy_len = 4;
    run("t3", 100);
    es = {9'h040, 9'h041, 9'h042, 9'h043, 9'h144};
    check_stream("t3", es);
    eg = {2'b10};
    check_grants("t3", eg);

    // Test 4: req1 owns the stream through a 4-cycle tvalid hole; req0 waits for the gap.
    do_reset();
    setup(1, 1, 4, 1);
    start_cyc[0] = 2;
    drop_beat[1] = 2; drop_left[1] = 4;
    run("t4", 100);
    es = {9'h040, 9'h041, 9'h042, 9'h143, 9'h100};
    check_stream("t4", es);
    eg = {2'b10, 2'b01};
    check_grants("t4", eg);
    check_eq("t4_gap", (gaps.size() > 0) ? 32'(gaps[0]) : 32'hFFFF_FFFF, 32'd14);

    // Test 5: asynchronous reset during beat 2 of a req1 frame.
    do_reset();
    @(negedge clk);
    s_tvalid = 2'b10; s_tdata = 16'h6100; s_tuser = 24'h004000; s_tlast = '0; m_tready = 1'b1;
    @(negedge clk); #1;
    check_eq("t5_grant", 32'(grant), 32'h2);
    @(negedge clk); s_tdata = 16'h6200; #1;
    check_eq("t5_beat2", 32'(m_tdata), 32'h62);
    check_eq("t5_beat2_valid", 32'(m_tvalid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t5_rst_mvalid", 32'(m_tvalid), 32'd0);
    check_eq("t5_rst_grant", 32'(grant), 32'd0);
    check_eq("t5_rst_busy", 32'(busy), 32'd0);
    check_eq("t5_rst_sready", 32'(s_tready), 32'd0);
    s_tvalid = 2'b11;
    @(negedge clk); rst_n = 1'b1; #1;
    check_eq("t5_post_idle", 32'(grant), 32'd0);
    @(negedge clk); #1;
    check_eq("t5_post_grant", 32'(grant), 32'h1);
    s_tvalid = '0;

`ifdef ARB_PKT_COUNT_EN
    // Test 6: per-requester frame counters and 16-bit wrap.
    do_reset();
    setup(1, 0, 1, 5);
    run("t6", 200);
    check_eq("t6_cnt1", 32'(pkt_count[31:16]), 32'd5);
    check_eq("t6_cnt0", 32'(pkt_count[15:0]), 32'd0);
    @(negedge clk);
    force dut.cnt_q = 32'hFFFF_0000;
    #1 release dut.cnt_q;
    setup(1, 0, 1, 1);
    run("t6w", 100);
    check_eq("t6_wrap", 32'(pkt_count[31:16]), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
